// File: rtl/mips_ctrl_pkg.sv
// Shared control encodings for the MIPS multicycle controller: RegDst codes,
// write-data sources, stack/link op codes and the stack-link sequencer states.
package mips_ctrl_pkg;

    localparam logic [2:0] RD_RT = 3'b000;
    localparam logic [2:0] RD_SP = 3'b001;
    localparam logic [2:0] RD_RA = 3'b010;
    localparam logic [2:0] RD_RD = 3'b011;
    localparam logic [2:0] RD_RS = 3'b100;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MDR = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_JAL  = 2'b11
    } stack_op_e;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_P_DEC  = 4'd1,
        S_P_MEM  = 4'd2,
        S_L_RD   = 4'd3,
        S_L_WAIT = 4'd4,
        S_L_WB   = 4'd5,
        S_L_INC  = 4'd6,
        S_J_LNK  = 4'd7,
        S_FAIL   = 4'd8
    } slc_state_e;

endpackage

// File: rtl/stack_link_ctrl.sv
// Multicycle sequencer for PUSH / POP / JAL register-file writes. Outputs are a
// pure Moore decode of the state register, so reset clears them asynchronously.
module stack_link_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int SP_STEP = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] op,
    output logic [2:0] reg_dst_sel,
    output logic       reg_write,
    output logic [1:0] wd_sel,
    output logic       alu_sub,
    output logic       alu_a_sp,
    output logic       mem_read,
    output logic       mem_write,
    output logic       busy,
    output logic       done,
    output logic       err
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15 || SP_STEP <= 0) begin : g_bad_param
            $error("stack_link_ctrl: MEM_LAT must be 1..15 and SP_STEP positive");
        end
    endgenerate

    // L_RD is the first read cycle, so the counter covers the remaining MEM_LAT-1.
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    slc_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
                if (start) begin
                    case (stack_op_e'(op))
                        OP_PUSH: state_d = S_P_DEC;
                        OP_POP:  state_d = S_L_RD;
                        OP_JAL:  state_d = S_J_LNK;
                        default: state_d = S_FAIL;
                    endcase
                end
            end
            S_P_DEC: state_d = S_P_MEM;
            S_P_MEM: state_d = S_IDLE;
            S_L_RD: begin
                cnt_d   = LAT_LOAD;
                state_d = (LAT_LOAD == 4'd0) ? S_L_WB : S_L_WAIT;
            end
            S_L_WAIT: begin
                // Saturate at zero so a stray entry can never wrap the counter.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
                state_d = (cnt_q <= 4'd1) ? S_L_WB : S_L_WAIT;
            end
            S_L_WB:  state_d = S_L_INC;
            S_L_INC: state_d = S_IDLE;
            S_J_LNK: state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        reg_dst_sel = RD_RT;
        reg_write   = 1'b0;
        wd_sel      = WD_ALU;
        alu_sub     = 1'b0;
        alu_a_sp    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        busy        = (state_q != S_IDLE);
        done        = 1'b0;
        err         = 1'b0;
        case (state_q)
            S_P_DEC: begin
                alu_a_sp    = 1'b1;
                alu_sub     = 1'b1;
                wd_sel      = WD_ALU;
                reg_dst_sel = RD_SP;
                reg_write   = 1'b1;
            end
            S_P_MEM: begin
                mem_write = 1'b1;
                done      = 1'b1;
            end
            S_L_RD, S_L_WAIT: begin
                mem_read = 1'b1;
            end
            S_L_WB: begin
                wd_sel      = WD_MDR;
                reg_dst_sel = RD_RT;
                reg_write   = 1'b1;
            end
            S_L_INC: begin
                alu_a_sp    = 1'b1;
                alu_sub     = 1'b0;
                wd_sel      = WD_ALU;
                reg_dst_sel = RD_SP;
                reg_write   = 1'b1;
                done        = 1'b1;
            end
            S_J_LNK: begin
                wd_sel      = WD_PC;
                reg_dst_sel = RD_RA;
                reg_write   = 1'b1;
                done        = 1'b1;
            end
            S_FAIL: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: begin
                busy = (state_q != S_IDLE);
            end
        endcase
    end

endmodule

// File: tb/tb_stack_link_ctrl.sv
// Bench for stack_link_ctrl: three instances (MEM_LAT = 2, 1, 15) driven from a
// transaction table and a few hand sequences, checked cycle by cycle from a queue.
module tb_stack_link_ctrl;
    import mips_ctrl_pkg::*;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start_v [3];
    logic [1:0] op_v    [3];
    logic [2:0] sel_w   [3];
    logic       rw_w    [3];
    logic [1:0] wd_w    [3];
    logic       sub_w   [3];
    logic       asp_w   [3];
    logic       mr_w    [3];
    logic       mw_w    [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic       err_w   [3];
    logic [12:0] obs    [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            stack_link_ctrl #(.MEM_LAT(lat_of(gi)), .SP_STEP(4)) u_dut (
                .clk         (clk),
                .reset_n     (reset_n),
                .start       (start_v[gi]),
                .op          (op_v[gi]),
                .reg_dst_sel (sel_w[gi]),
                .reg_write   (rw_w[gi]),
                .wd_sel      (wd_w[gi]),
                .alu_sub     (sub_w[gi]),
                .alu_a_sp    (asp_w[gi]),
                .mem_read    (mr_w[gi]),
                .mem_write   (mw_w[gi]),
                .busy        (busy_w[gi]),
                .done        (done_w[gi]),
                .err         (err_w[gi])
            );
            assign obs[gi] = {sel_w[gi], rw_w[gi], wd_w[gi], sub_w[gi], asp_w[gi],
                              mr_w[gi], mw_w[gi], busy_w[gi], done_w[gi], err_w[gi]};
        end
    endgenerate

    // Vector layout: sel[12:10] rw[9] wd[8:7] sub[6] asp[5] mr[4] mw[3] busy[2] done[1] err[0]
    function automatic logic [12:0] mk(input logic [2:0] sel, input logic rw, input logic [1:0] wd,
                                       input logic sub, input logic asp, input logic mr,
                                       input logic mw, input logic busy, input logic done,
                                       input logic err);
        return {sel, rw, wd, sub, asp, mr, mw, busy, done, err};
    endfunction

    int total = 0;
    int bad   = 0;
    logic [12:0] exp_q [$];

    task automatic push_model(input logic [1:0] op, input int lat);
        case (op)
            2'b01: begin
                exp_q.push_back(mk(3'b001, 1, 2'b00, 1, 1, 0, 0, 1, 0, 0));
                exp_q.push_back(mk(3'b000, 0, 2'b00, 0, 0, 0, 1, 1, 1, 0));
            end
            2'b10: begin
                for (int k = 0; k < lat; k++)
                    exp_q.push_back(mk(3'b000, 0, 2'b00, 0, 0, 1, 0, 1, 0, 0));
                exp_q.push_back(mk(3'b000, 1, 2'b01, 0, 0, 0, 0, 1, 0, 0));
                exp_q.push_back(mk(3'b001, 1, 2'b00, 0, 1, 0, 0, 1, 1, 0));
            end
            2'b11: exp_q.push_back(mk(3'b010, 1, 2'b10, 0, 0, 0, 0, 1, 1, 0));
            default: exp_q.push_back(mk(3'b000, 0, 2'b00, 0, 0, 0, 0, 1, 1, 1));
        endcase
        exp_q.push_back(13'd0);
        exp_q.push_back(13'd0);
    endtask

    task automatic check_vec(input int inst, input logic [12:0] want, input string nm);
        logic [12:0] got;
        got = obs[inst];
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst%0d got=%013b want=%013b", nm, inst, got, want);
        end
        total++;
        assert (!(got[9] && got[3]) && got[12:10] <= 3'b010)
        else begin
            bad++;
            $display("FAIL invariant_%s inst%0d rw=%b mw=%b sel=%03b", nm, inst, got[9], got[3], got[12:10]);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic run_txn(input int inst, input logic [1:0] op, input bit hold, input string nm,
                           output int busy_cyc, output int dones, output int errs);
        logic [12:0] e;
        busy_cyc = 0;
        dones    = 0;
        errs     = 0;
        push_model(op, lat_of(inst));
        @(negedge clk);
        start_v[inst] = 1'b1;
        op_v[inst]    = op;
        @(posedge clk);
        #1;
        if (!hold) start_v[inst] = 1'b0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_vec(inst, e, nm);
            if (busy_w[inst]) busy_cyc++;
            if (done_w[inst]) dones++;
            if (err_w[inst])  errs++;
            if (hold && e[1]) begin
                @(posedge clk);
                #1;
                start_v[inst] = 1'b0;
            end
        end
    endtask

    typedef struct {
        int         inst;
        logic [1:0] op;
        int         exp_busy;
        int         exp_err;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, dn, er;
        tbl[0] = '{0, OP_PUSH, 2,  0};
        tbl[1] = '{0, OP_POP,  4,  0};
        tbl[2] = '{0, OP_JAL,  1,  0};
        tbl[3] = '{0, OP_NOP,  1,  1};
        tbl[4] = '{1, OP_POP,  3,  0};
        tbl[5] = '{2, OP_POP,  17, 0};
        tbl[6] = '{1, OP_PUSH, 2,  0};
        tbl[7] = '{2, OP_JAL,  1,  0};
        tbl[8] = '{1, OP_NOP,  1,  1};

        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            op_v[i]    = 2'b00;
        end
        #12;
        for (int i = 0; i < 3; i++) check_vec(i, 13'd0, "reset_state");
        @(negedge clk);
        reset_n = 1'b1;

        for (int t = 0; t < 9; t++) begin
            run_txn(tbl[t].inst, tbl[t].op, 1'b0, "table", bc, dn, er);
            check_int("busy_cycles", bc, tbl[t].exp_busy);
            check_int("done_count", dn, 1);
            check_int("err_count", er, tbl[t].exp_err);
            $display("txn %0d inst=%0d lat=%0d op=%0d busy=%0d done=%0d err=%0d",
                     t, tbl[t].inst, lat_of(tbl[t].inst), tbl[t].op, bc, dn, er);
        end

        // start held high for the whole POP, including the done cycle
        run_txn(0, OP_POP, 1'b1, "pop_start_held", bc, dn, er);
        check_int("held_busy_cycles", bc, 4);
        check_int("held_done_count", dn, 1);
        $display("txn held-start POP inst=0 busy=%0d done=%0d", bc, dn);

        // reset asserted while the lat-15 POP sits in L_WAIT
        @(negedge clk);
        start_v[2] = 1'b1;
        op_v[2]    = OP_POP;
        @(posedge clk);
        #1;
        start_v[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_vec(2, mk(3'b000, 0, 2'b00, 0, 0, 1, 0, 1, 0, 0), "pop_read_before_rst");
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_vec(2, 13'd0, "async_reset_clear");
        @(negedge clk);
        check_vec(2, 13'd0, "reset_held");
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        check_vec(2, 13'd0, "post_reset_idle");
        $display("txn reset-during-wait inst=2 outputs=%013b", obs[2]);
        run_txn(2, OP_PUSH, 1'b0, "push_after_rst", bc, dn, er);
        check_int("post_rst_push_busy", bc, 2);
        check_int("post_rst_push_done", dn, 1);
        $display("txn push-after-reset inst=2 busy=%0d done=%0d", bc, dn);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
